// File: rtl/lynx_mem_ctrl_if.sv
// Lynx memory-controller bus bundle: Z80 side, ROM/RAM/video-plane side,
// keyboard/tape inputs and the registered bank/video-control outputs.
interface lynx_mem_ctrl_if #(
    parameter int NPLANES = 2,
    parameter int RAM_AW  = 16
);
    logic                   ce;
    logic [1:0]             mode;
    logic [15:0]            a;
    logic                   mreq_n;
    logic                   iorq_n;
    logic                   wr_n;
    logic [7:0]             cpu_do;
    logic [7:0]             cpu_di;
    logic                   wait_n;
    logic                   de;
    logic                   cas;
    logic [7:0]             kbd_q;
    logic                   ear;
    logic [14:0]            rom_a;
    logic [7:0]             rom_q;
    logic [RAM_AW-1:0]      ram_a;
    logic                   ram_we;
    logic [7:0]             ram_q;
    logic [13:0]            vram_a;
    logic [NPLANES-1:0]     vram_we;
    logic [8*NPLANES-1:0]   vram_q;
    logic [NPLANES-1:0]     plane_en;
    logic [7:0]             bank;
    logic [4:0]             vctl;

    // Controller view
    modport slave (
        input  ce, mode, a, mreq_n, iorq_n, wr_n, cpu_do, de, cas, kbd_q, ear,
               rom_q, ram_q, vram_q,
        output cpu_di, wait_n, rom_a, ram_a, ram_we, vram_a, vram_we,
               plane_en, bank, vctl
    );

    // CPU / memory-system view
    modport master (
        output ce, mode, a, mreq_n, iorq_n, wr_n, cpu_do, de, cas, kbd_q, ear,
               rom_q, ram_q, vram_q,
        input  cpu_di, wait_n, rom_a, ram_a, ram_we, vram_a, vram_we,
               plane_en, bank, vctl
    );
endinterface

// File: rtl/lynx_mem_ctrl.sv
// Lynx 48K/96K/Scorpio memory map, bank (0x7F) and video-control (0x80)
// registers, CAS plane-blank toggle and a WAIT FSM that stalls CPU accesses
// to video RAM while the CRTC is in active display.
module lynx_mem_ctrl #(
    parameter int NPLANES  = 2,
    parameter int RAM_AW   = 16,
    parameter bit WAIT_EN  = 1'b1,
    parameter int WAIT_MAX = 63
) (
    input  logic          clock,
    input  logic          reset,
    lynx_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // r_vctl holds vctl[5:1]: r_vctl[0]=vctl[1] ... r_vctl[4]=vctl[5]
    logic [7:0]         r_bank;
    logic [4:0]         r_vctl;
    logic               r_cas_d;
    logic               r_cas_tog;
    logic [5:0]         r_wcnt;
    state_t             r_state;

    state_t             w_state_nxt;
    logic [5:0]         w_wcnt_nxt;
    logic               w_wait_n;
    logic               w_hold_req;

    logic               w_io_wr;
    logic               w_sel_bank;
    logic               w_sel_vctl;
    logic               w_mode0;
    logic               w_rom_lo;
    logic               w_rom_hi;
    logic               w_rom_hit;
    logic               w_ram_hit;
    logic               w_vid_hit;
    logic               w_plane_found;
    logic [7:0]         w_plane_q;
    logic [7:0]         w_mem_q;
    logic [7:0]         w_io_q;
    logic [NPLANES-1:0] w_vwe_raw;
    logic               w_vid_rd;
    logic               w_vid_wr;
    logic               w_vid_tgt;
    logic               w_wr_cyc;
    logic [15:0]        w_ram_full;

    // Port decode: 0x7F is a full 7-bit match, 0x80 is partially decoded
    assign w_io_wr    = bus.ce & ~bus.iorq_n & ~bus.wr_n;
    assign w_sel_bank = (bus.a[6:0] == 7'h7F);
    assign w_sel_vctl = bus.a[7] & ~bus.a[6] & ~bus.a[2] & ~bus.a[1];

    // Bank and video-control registers; the access in flight still sees the old values
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank <= 8'h00;
            r_vctl <= 5'b00110;
        end else if (w_io_wr) begin
            if (w_sel_bank) r_bank <= bus.cpu_do;
            if (w_sel_vctl) r_vctl <= bus.cpu_do[5:1];
        end
    end

    // CAS key falling-edge detector toggles the plane-blank flag once per press
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cas_d   <= 1'b0;
            r_cas_tog <= 1'b0;
        end else if (bus.ce) begin
            r_cas_d <= bus.cas;
            if (r_cas_d && !bus.cas) r_cas_tog <= ~r_cas_tog;
        end
    end

    // Address map regions
    assign w_mode0   = (bus.mode == 2'd0);
    assign w_rom_lo  = (bus.a[15:14] == 2'b00);
    assign w_rom_hi  = (bus.a[15:13] == 3'b010);
    assign w_rom_hit = ~r_bank[4] & (w_rom_lo | w_rom_hi);
    assign w_ram_hit = ~r_bank[5];
    assign w_vid_hit = r_bank[6];

    // Lowest plane whose vctl[2+k] select bit is clear supplies video read data
    always_comb begin
        w_plane_found = 1'b0;
        w_plane_q     = 8'hFF;
        for (int k = 0; k < NPLANES; k++) begin
            if (!w_plane_found && !r_vctl[1+k]) begin
                w_plane_found = 1'b1;
                w_plane_q     = bus.vram_q[8*k +: 8];
            end
        end
    end

    // Memory read priority: ROM, RAM, video plane, open bus
    always_comb begin
        w_mem_q = 8'hFF;
        if (w_rom_hit) begin
            w_mem_q = (w_mode0 && w_rom_hi) ? 8'hFF : bus.rom_q;
        end else if (w_ram_hit) begin
            w_mem_q = bus.ram_q;
        end else if (w_vid_hit && w_plane_found) begin
            w_mem_q = w_plane_q;
        end
    end

    assign w_io_q = w_sel_vctl ? {bus.kbd_q[7:1], (r_vctl[0] ? bus.ear : bus.kbd_q[0])}
                               : 8'hFF;
    assign bus.cpu_di = ~bus.iorq_n ? w_io_q : w_mem_q;

    // Per-plane write select before WAIT gating; planes beyond bank[3] are unmapped
    always_comb begin
        w_vwe_raw = '0;
        for (int k = 0; k < NPLANES && k < 3; k++) begin
            w_vwe_raw[k] = r_bank[1+k] & r_vctl[4];
        end
    end

    // A video target is a read that falls through to the video planes or any plane write
    assign w_vid_rd   = bus.wr_n & ~w_rom_hit & ~w_ram_hit & w_vid_hit;
    assign w_vid_wr   = ~bus.wr_n & (|w_vwe_raw);
    assign w_vid_tgt  = ~bus.mreq_n & (w_vid_rd | w_vid_wr);
    assign w_hold_req = WAIT_EN & w_vid_tgt & bus.de;

    // WAIT FSM state and counter register, advancing on CPU clock enables
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 6'd0;
        end else if (bus.ce) begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // WAIT FSM next state; wait_n drops in the same cycle a held access is seen
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_wait_n    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_hold_req) begin
                    w_wait_n    = 1'b0;
                    w_wcnt_nxt  = 6'd0;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_wait_n   = 1'b0;
                w_wcnt_nxt = r_wcnt + 6'd1;
                if (!bus.de || (w_wcnt_nxt == 6'(WAIT_MAX))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.mreq_n) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write strobes are suppressed while the CPU is being held
    assign w_wr_cyc    = ~bus.mreq_n & ~bus.wr_n & w_wait_n;
    assign bus.ram_we  = w_wr_cyc & ~r_bank[0];
    assign bus.vram_we = {NPLANES{w_wr_cyc}} & w_vwe_raw;
    assign bus.wait_n  = w_wait_n;

    // Address outputs; the 48K map folds out a[13]
    assign bus.rom_a   = w_mode0 ? {1'b0, bus.a[13:0]} : bus.a[14:0];
    assign w_ram_full  = w_mode0 ? {2'b00, bus.a[14], bus.a[12:0]} : bus.a;
    assign bus.ram_a   = w_ram_full[RAM_AW-1:0];
    assign bus.vram_a  = {bus.a[14], bus.a[12:0]};

    // CAS blanking applies to the first two planes only
    always_comb begin
        bus.plane_en = '1;
        for (int k = 0; k < NPLANES && k < 2; k++) begin
            bus.plane_en[k] = ~(r_cas_tog & r_vctl[1+k]);
        end
    end

    assign bus.bank = r_bank;
    assign bus.vctl = r_vctl;

endmodule

// File: tb/tb_lynx_mem_ctrl.sv
// Directed bench for lynx_mem_ctrl: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_lynx_mem_ctrl;
    localparam int NPLANES  = 2;
    localparam int RAM_AW   = 16;
    localparam int WAIT_MAX = 63;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lynx_mem_ctrl_if #(.NPLANES(NPLANES), .RAM_AW(RAM_AW)) bus();

    lynx_mem_ctrl #(
        .NPLANES (NPLANES),
        .RAM_AW  (RAM_AW),
        .WAIT_EN (1'b1),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            e = 32'hDEAD_BEEF;
            t = "scoreboard_underflow";
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
        end
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] d);
        bus.a      = addr;
        bus.cpu_do = d;
        bus.iorq_n = 1'b0;
        bus.wr_n   = 1'b0;
        tick();
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
    endtask

    task automatic mem_rd(input logic [15:0] addr);
        bus.a      = addr;
        bus.wr_n   = 1'b1;
        bus.mreq_n = 1'b0;
        #1;
    endtask

    task automatic mem_wr(input logic [15:0] addr, input logic [7:0] d);
        bus.a      = addr;
        bus.cpu_do = d;
        bus.wr_n   = 1'b0;
        bus.mreq_n = 1'b0;
        #1;
    endtask

    task automatic bus_idle();
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;

        reset      = 1'b1;
        bus.ce     = 1'b1;
        bus.mode   = 2'd1;
        bus.a      = 16'h0000;
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        bus.cpu_do = 8'h00;
        bus.de     = 1'b0;
        bus.cas    = 1'b0;
        bus.kbd_q  = 8'hFF;
        bus.ear    = 1'b1;
        bus.rom_q  = 8'hA5;
        bus.ram_q  = 8'h3C;
        bus.vram_q = {8'h22, 8'h11};
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        sb_push("rst_bank", 32'h00);      sb_check(32'(bus.bank));
        sb_push("rst_vctl", 32'h06);      sb_check(32'(bus.vctl));
        sb_push("rst_wait_n", 32'h1);     sb_check(32'(bus.wait_n));
        sb_push("rst_plane_en", 32'h3);   sb_check(32'(bus.plane_en));

        // Bank/vctl writes and a plane-0 video write
        io_wr(16'h007F, 8'h02);
        sb_push("bank_wr_02", 32'h02);    sb_check(32'(bus.bank));
        io_wr(16'h0080, 8'h20);
        sb_push("vctl_wr_20", 32'h10);    sb_check(32'(bus.vctl));
        mem_wr(16'h4000, 8'h55);
        sb_push("vwe_bank02", 32'h1);     sb_check(32'(bus.vram_we));
        sb_push("rwe_bank02", 32'h1);     sb_check(32'(bus.ram_we));
        sb_push("vram_a_4000", 32'h2000); sb_check(32'(bus.vram_a));
        bus_idle();
        io_wr(16'h007F, 8'h03);
        mem_wr(16'h4000, 8'h55);
        sb_push("vwe_bank03", 32'h1);     sb_check(32'(bus.vram_we));
        sb_push("rwe_bank03", 32'h0);     sb_check(32'(bus.ram_we));
        bus_idle();
        bus.ce = 1'b0;
        io_wr(16'h007F, 8'hFF);
        bus.ce = 1'b1;
        #1;
        sb_push("bank_no_ce", 32'h03);    sb_check(32'(bus.bank));

        // Memory map by mode
        bus.mode = 2'd0;
        mem_rd(16'h2000);
        sb_push("m0_rd_2000", 32'hA5);    sb_check(32'(bus.cpu_di));
        sb_push("m0_rom_a", 32'h2000);    sb_check(32'(bus.rom_a));
        mem_rd(16'h4000);
        sb_push("m0_rd_4000", 32'hFF);    sb_check(32'(bus.cpu_di));
        mem_rd(16'h6001);
        sb_push("m0_rd_6001", 32'h3C);    sb_check(32'(bus.cpu_di));
        sb_push("m0_ram_a", 32'h2001);    sb_check(32'(bus.ram_a));
        sb_push("m0_rom_a_fold", 32'h2001); sb_check(32'(bus.rom_a));
        bus.mode = 2'd1;
        mem_rd(16'h4000);
        sb_push("m1_rd_4000", 32'hA5);    sb_check(32'(bus.cpu_di));
        sb_push("m1_rom_a", 32'h4000);    sb_check(32'(bus.rom_a));
        mem_rd(16'h8000);
        sb_push("m1_ram_a", 32'h8000);    sb_check(32'(bus.ram_a));
        bus.mode = 2'd3;
        mem_rd(16'h4000);
        sb_push("m3_rd_4000", 32'hA5);    sb_check(32'(bus.cpu_di));
        bus.mode = 2'd1;
        bus_idle();

        // Video read with display off, then write stalled during display
        io_wr(16'h007F, 8'h62);
        mem_rd(16'h6000);
        sb_push("vid_rd_p0", 32'h11);     sb_check(32'(bus.cpu_di));
        sb_push("vid_rd_nowait", 32'h1);  sb_check(32'(bus.wait_n));
        bus_idle();
        bus.de = 1'b1;
        mem_wr(16'h4000, 8'h77);
        sb_push("vwr_de_wait", 32'h0);    sb_check(32'(bus.wait_n));
        sb_push("vwr_de_vwe", 32'h0);     sb_check(32'(bus.vram_we));
        sb_push("vwr_de_rwe", 32'h0);     sb_check(32'(bus.ram_we));
        bus_idle();
        bus.de = 1'b0;
        tick();

        // Hold released early by de falling
        bus.de = 1'b1;
        mem_rd(16'h6000);
        sb_push("hold_enter_wait", 32'h0); sb_check(32'(bus.wait_n));
        tick();
        for (int i = 0; i < 10; i++) tick();
        bus.de = 1'b0;
        #1;
        sb_push("hold_10_wait", 32'h0);   sb_check(32'(bus.wait_n));
        tick();
        sb_push("de_fall_release", 32'h1); sb_check(32'(bus.wait_n));
        bus.de = 1'b1;
        tick();
        sb_push("done_no_rehold", 32'h1); sb_check(32'(bus.wait_n));
        bus_idle();
        tick();

        // Hold released by the cycle limit with de held high
        mem_rd(16'h6000);
        sb_push("idle_again_wait", 32'h0); sb_check(32'(bus.wait_n));
        tick();
        n = 0;
        while (bus.wait_n == 1'b0 && n < 200) begin
            tick();
            n++;
        end
        sb_push("wait_max_ticks", 32'(WAIT_MAX)); sb_check(32'(n));
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.wait_n == 1'b0) lows++;
        end
        sb_push("max_no_rehold", 32'h0);  sb_check(32'(lows));
        bus_idle();
        bus.de = 1'b0;
        tick();

        // Plane priority for video reads
        io_wr(16'h0080, 8'h24);
        mem_rd(16'h6000);
        sb_push("vid_rd_p1", 32'h22);     sb_check(32'(bus.cpu_di));
        bus_idle();
        io_wr(16'h0080, 8'h2C);
        mem_rd(16'h6000);
        sb_push("vid_rd_none", 32'hFF);   sb_check(32'(bus.cpu_di));
        bus_idle();

        // CAS toggle blanks plane 0 only
        io_wr(16'h0080, 8'h04);
        sb_push("cas_init", 32'h3);       sb_check(32'(bus.plane_en));
        bus.cas = 1'b1; tick();
        bus.cas = 1'b0; tick();
        sb_push("cas_press1", 32'h2);     sb_check(32'(bus.plane_en));
        bus.cas = 1'b1; tick();
        sb_push("cas_rise_hold", 32'h2);  sb_check(32'(bus.plane_en));
        bus.cas = 1'b0; tick();
        sb_push("cas_press2", 32'h3);     sb_check(32'(bus.plane_en));

        // Reset during HOLD
        io_wr(16'h0080, 8'h00);
        bus.cas = 1'b1; tick();
        bus.cas = 1'b0; tick();
        io_wr(16'h007F, 8'h60);
        bus.de = 1'b1;
        mem_rd(16'h6000);
        tick();
        tick();
        tick();
        sb_push("pre_rst_hold", 32'h0);   sb_check(32'(bus.wait_n));
        reset = 1'b1;
        tick();
        sb_push("midhold_wait_n", 32'h1); sb_check(32'(bus.wait_n));
        sb_push("midhold_bank", 32'h00);  sb_check(32'(bus.bank));
        sb_push("midhold_vctl", 32'h06);  sb_check(32'(bus.vctl));
        sb_push("midhold_plane", 32'h3);  sb_check(32'(bus.plane_en));
        reset = 1'b0;
        bus_idle();
        bus.de = 1'b0;
        tick();

        // Keyboard port with tape input on bit 0
        io_wr(16'h0080, 8'h02);
        bus.ear = 1'b0;
        bus.a = 16'h0080; bus.wr_n = 1'b1; bus.iorq_n = 1'b0; #1;
        sb_push("in80_ear0", 32'hFE);     sb_check(32'(bus.cpu_di));
        bus.ear = 1'b1; bus.kbd_q = 8'hA6; #1;
        sb_push("in80_ear1", 32'hA7);     sb_check(32'(bus.cpu_di));
        bus_idle();
        io_wr(16'h0080, 8'h00);
        bus.a = 16'h0080; bus.wr_n = 1'b1; bus.iorq_n = 1'b0; #1;
        sb_push("in80_kbd0", 32'hA6);     sb_check(32'(bus.cpu_di));
        bus_idle();

        sb_push("sb_drained", 32'h0);     sb_check(32'(exp_q.size() - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
